// File: rtl/alu_ctrl.sv
// alu_ctrl: 4-register instruction sequencer that drives an external ALU (optional zflag under ALU_CTRL_ZFLAG_EN).
// Latency: register written at the edge after acceptance; wb_valid in the following cycle; one instruction per 3 cycles.
// Backpressure: instr_ready only in IDLE; instr_valid while busy is ignored and the word is taken in the next IDLE cycle.
module alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_res,
    output logic        wb_valid,
    output logic [1:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic        illegal
`ifdef ALU_CTRL_ZFLAG_EN
    ,
    output logic        zflag
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

    state_t      state, state_nxt;
    logic [15:0] ir;
    logic [7:0]  regs [4];

    logic [2:0]  ir_op;
    logic [1:0]  ir_rd;
    logic [1:0]  ir_rs;
    logic [7:0]  ir_imm;
    logic [7:0]  rd_val;
    logic [7:0]  rs_val;
    logic        instr_legal;
    logic        unused_rsvd;

    assign ir_op       = ir[15:13];
    assign ir_rd       = ir[12:11];
    assign ir_rs       = ir[10:9];
    assign ir_imm      = ir[7:0];
    assign unused_rsvd = ir[8];
    assign rd_val      = regs[ir_rd];
    assign rs_val      = regs[ir_rs];
    // Opcodes 110 and 111 are the only rejected encodings.
    assign instr_legal = (instr[15:14] != 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ir      <= '0;
            wb_addr <= '0;
            wb_data <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr_valid) ir <= instr;
            if (state == EXEC) begin
                regs[ir_rd] <= alu_res;
                wb_addr     <= ir_rd;
                wb_data     <= alu_res;
            end
        end
    end

`ifdef ALU_CTRL_ZFLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) zflag <= 1'b0;
        else if (state == EXEC) zflag <= (alu_res == 8'd0);
    end
`endif

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        wb_valid    = 1'b0;
        illegal     = 1'b0;
        alu_op      = 8'd0;
        alu_a       = 8'd0;
        alu_b       = 8'd0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = instr_legal ? EXEC : ERR;
            end
            EXEC: begin
                state_nxt = WB;
                // Operands come from the pre-write register values, so Rd==Rs is safe.
                case (ir_op)
                    3'b000: alu_a = ir_imm;
                    3'b001: alu_a = rs_val;
                    3'b010: begin alu_op = 8'd1; alu_a = rd_val; alu_b = rs_val; end
                    3'b011: begin alu_op = 8'd1; alu_a = rd_val; alu_b = ~rs_val + 8'd1; end
                    3'b100: begin alu_op = 8'd2; alu_a = rd_val; alu_b = rs_val; end
                    3'b101: begin alu_op = 8'd3; alu_a = rd_val; alu_b = rs_val; end
                    default: ;
                endcase
            end
            WB: begin
                wb_valid  = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                illegal   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: transaction-level expectation model plus directed vectors with literal expectations.
module tb_alu_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_op, alu_a, alu_b, alu_res;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        illegal;
`ifdef ALU_CTRL_ZFLAG_EN
    logic        zflag;
`endif

    alu_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal)
`ifdef ALU_CTRL_ZFLAG_EN
        , .zflag(zflag)
`endif
    );

    // External ALU
    always_comb begin
        case (alu_op)
            8'd0:    alu_res = alu_a;
            8'd1:    alu_res = alu_a + alu_b;
            8'd2:    alu_res = alu_a & alu_b;
            8'd3:    alu_res = alu_a | alu_b;
            default: alu_res = 8'd0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected per-cycle behaviour: the cycle after each accepted instruction follows a fixed schedule.
    typedef struct {
        bit rdy; int op; int a; int b; bit wbv; bit ill; int wa; int wd;
    } exp_t;

    exp_t q[$];
    exp_t cur = '{rdy: 1'b1, op: 0, a: 0, b: 0, wbv: 1'b0, ill: 1'b0, wa: 0, wd: 0};
    exp_t idle_e = '{rdy: 1'b1, op: 0, a: 0, b: 0, wbv: 1'b0, ill: 1'b0, wa: 0, wd: 0};
    int   m_regs [4] = '{0, 0, 0, 0};
    int   m_wa = 0, m_wd = 0, m_z = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = idle_e;
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_wa = 0; m_wd = 0; m_z = 0;
        end else begin
            if (cur.rdy && instr_valid) begin
                int opc, d, s, imm, rdv, rsv, res;
                exp_t ex, wb;
                opc = int'(instr[15:13]); d = int'(instr[12:11]); s = int'(instr[10:9]);
                imm = int'(instr[7:0]); rdv = m_regs[d]; rsv = m_regs[s];
                ex = idle_e; ex.rdy = 1'b0;
                wb = idle_e; wb.rdy = 1'b0;
                res = 0;
                case (opc)
                    0: begin res = imm; ex.a = imm; end
                    1: begin res = rsv; ex.a = rsv; end
                    2: begin res = (rdv + rsv) % 256; ex.op = 1; ex.a = rdv; ex.b = rsv; end
                    3: begin res = (rdv - rsv + 256) % 256; ex.op = 1; ex.a = rdv; ex.b = (256 - rsv) % 256; end
                    4: begin res = rdv & rsv; ex.op = 2; ex.a = rdv; ex.b = rsv; end
                    5: begin res = rdv | rsv; ex.op = 3; ex.a = rdv; ex.b = rsv; end
                    default: ;
                endcase
                if (opc >= 6) begin
                    ex.ill = 1'b1;
                    q.push_back(ex);
                end else begin
                    wb.wbv = 1'b1; wb.wa = d; wb.wd = res;
                    m_regs[d] = res;
                    q.push_back(ex);
                    q.push_back(wb);
                end
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = idle_e;
            if (cur.wbv) begin
                m_wa = cur.wa; m_wd = cur.wd; m_z = (cur.wd == 0) ? 1 : 0;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("instr_ready", int'(instr_ready), int'(cur.rdy));
            chk("alu_op", int'(alu_op), cur.op);
            chk("alu_a", int'(alu_a), cur.a);
            chk("alu_b", int'(alu_b), cur.b);
            chk("wb_valid", int'(wb_valid), int'(cur.wbv));
            chk("illegal", int'(illegal), int'(cur.ill));
            chk("wb_addr", int'(wb_addr), m_wa);
            chk("wb_data", int'(wb_data), m_wd);
`ifdef ALU_CTRL_ZFLAG_EN
            chk("zflag", int'(zflag), m_z);
`endif
        end
    end

    // Acceptance monitor on the DUT handshake
    int cyc = 0;
    bit acc_s = 1'b0;
    int acc_q[$];
    always @(negedge clk) acc_s = instr_ready && instr_valid && !rst;
    always @(posedge clk) begin
        cyc++;
        if (acc_s) acc_q.push_back(cyc);
    end

    function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int imm);
        logic [15:0] w;
        w = {op[2:0], rd[1:0], rs[1:0], 1'b0, imm[7:0]};
        return w;
    endfunction

    int c1_op, c1_a, c1_b, c1_wbv, c1_ill;
    int c2_wbv, c2_wa, c2_wd, c2_rdy, c2_ill, c2_z;

    task automatic send(input logic [15:0] w, input bit keep);
        bit ok;
        #1;
        instr = w;
        instr_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (instr_ready) ok = 1'b1;
        end
        chk("accept_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
        if (!keep) instr_valid = 1'b0;
        @(negedge clk);
        c1_op = int'(alu_op); c1_a = int'(alu_a); c1_b = int'(alu_b);
        c1_wbv = int'(wb_valid); c1_ill = int'(illegal);
        @(negedge clk);
        c2_wbv = int'(wb_valid); c2_wa = int'(wb_addr); c2_wd = int'(wb_data);
        c2_rdy = int'(instr_ready); c2_ill = int'(illegal);
`ifdef ALU_CTRL_ZFLAG_EN
        c2_z = int'(zflag);
`else
        c2_z = 0;
`endif
    endtask

    initial begin
        rst = 1'b0; instr_valid = 1'b0; instr = 16'h0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(instr_ready), 1);
        chk("reset_wb_addr", int'(wb_addr), 0);
        chk("reset_wb_data", int'(wb_data), 0);
        chk("reset_wb_valid", int'(wb_valid), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 5 + 3 = 8
        send(mk(0, 1, 0, 8'h05), 1'b0);
        send(mk(0, 2, 0, 8'h03), 1'b0);
        send(mk(2, 1, 2, 0), 1'b0);
        chk("add_alu_op", c1_op, 1);
        chk("add_alu_a", c1_a, 8'h05);
        chk("add_alu_b", c1_b, 8'h03);
        chk("add_wb_valid", c2_wbv, 1);
        chk("add_wb_addr", c2_wa, 1);
        chk("add_wb_data", c2_wd, 8'h08);

        // 3 - 5 = 0xFE, negated operand 0xFB
        send(mk(0, 1, 0, 8'h03), 1'b0);
        send(mk(0, 2, 0, 8'h05), 1'b0);
        send(mk(3, 1, 2, 0), 1'b0);
        chk("sub_alu_b", c1_b, 8'hFB);
        chk("sub_wb_data", c2_wd, 8'hFE);
        send(mk(1, 0, 1, 0), 1'b0);
        chk("mov_r1_after_sub", c2_wd, 8'hFE);

        // 0xFF + 0x01 wraps to 0
        send(mk(0, 0, 0, 8'hFF), 1'b0);
        send(mk(0, 3, 0, 8'h01), 1'b0);
        send(mk(2, 0, 3, 0), 1'b0);
        chk("wrap_wb_data", c2_wd, 8'h00);
`ifdef ALU_CTRL_ZFLAG_EN
        chk("wrap_zflag", c2_z, 1);
`endif

        // Illegal opcode targeting R1
        send(mk(6, 1, 2, 8'h77), 1'b0);
        chk("ill_pulse", c1_ill, 1);
        chk("ill_no_wb", c1_wbv, 0);
        chk("ill_one_cycle", c2_ill, 0);
        chk("ill_ready_back", c2_rdy, 1);
        send(mk(1, 2, 1, 0), 1'b0);
        chk("ill_r1_kept", c2_wd, 8'hFE);

        // Rd == Rs uses the old value: 0xFE + 0xFE = 0xFC
        send(mk(2, 1, 1, 0), 1'b0);
        chk("self_add", c2_wd, 8'hFC);
        send(mk(0, 2, 0, 8'hF0), 1'b0);
        send(mk(4, 1, 2, 0), 1'b0);
        chk("and_alu_op", c1_op, 2);
        chk("and_wb_data", c2_wd, 8'hF0);
        send(mk(0, 3, 0, 8'h0F), 1'b0);
        send(mk(5, 1, 3, 0), 1'b0);
        chk("or_wb_data", c2_wd, 8'hFF);

        // Valid held high across three instructions; reserved bit set on one
        acc_q.delete();
        send(mk(0, 0, 0, 8'h11), 1'b1);
        send(mk(0, 1, 0, 8'h22) | 16'h0100, 1'b1);
        send(mk(0, 2, 0, 8'h33), 1'b0);
        chk("stream_accepts", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("stream_gap1", acc_q[1] - acc_q[0], 3);
            chk("stream_gap2", acc_q[2] - acc_q[1], 3);
        end
        send(mk(1, 3, 1, 0), 1'b0);
        chk("stream_r1", c2_wd, 8'h22);
        send(mk(1, 3, 2, 0), 1'b0);
        chk("stream_r2", c2_wd, 8'h33);

        // Reset during EXEC of LOADI R2,0xAA
        #1;
        instr = mk(0, 2, 0, 8'hAA);
        instr_valid = 1'b1;
        for (int n = 0; n < 20 && !instr_ready; n++) @(negedge clk);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_ready", int'(instr_ready), 1);
        chk("rst_exec_wb_valid", int'(wb_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_no_wb", int'(wb_valid), 0);
        end
        send(mk(1, 3, 2, 0), 1'b0);
        chk("rst_r2_clear", c2_wd, 8'h00);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction word present on instr.
REQ-005 instr_ready  output  1  block can accept an instruction; high only in IDLE.
REQ-006 instr  input  16  fields: [15:13] opcode, [12:11] Rd, [10:9] Rs, [8] reserved (ignored), [7:0] imm.
REQ-007 alu_op  output  8  operation to the ALU; [7:3] always 0; [2:0] 000 forward alu_a, 001 add, 010 and, 011 or.
REQ-008 alu_a, alu_b  output  8 each  ALU operands.
REQ-009 alu_res  input  8  ALU result; combinational from alu_op/alu_a/alu_b in the same cycle.
REQ-010 wb_valid  output  1  one-cycle pulse: register write performed.
REQ-011 wb_addr  output  2 and wb_data  output  8  register index and value written.
REQ-012 illegal  output  1  one-cycle pulse: opcode rejected.

Function
REQ-013 Four 8-bit registers R0-R3 SHALL be held internally.
REQ-014 Opcodes SHALL be: 000 LOADI Rd=imm; 001 MOV Rd=Rs; 010 ADD Rd=Rd+Rs; 011 SUB Rd=Rd-Rs; 100 AND Rd=Rd&Rs; 101 OR Rd=Rd|Rs; 110/111 illegal.
REQ-015 Operand mapping in EXEC: LOADI op 000, a=imm; MOV op 000, a=Rs; ADD op 001, a=Rd, b=Rs; SUB op 001, a=Rd, b=(~Rs)+1 mod 256; AND op 010; OR op 011 (a=Rd, b=Rs); unused b=0.
REQ-016 Outside EXEC, alu_op, alu_a and alu_b SHALL be 0.
REQ-017 Arithmetic SHALL wrap modulo 256; no carry or overflow output.
REQ-018 FSM states: IDLE, EXEC, WB, ERR.
REQ-019 IDLE: instr_ready=1; on instr_valid at an edge, instruction is latched; legal -> EXEC, illegal -> ERR.
REQ-020 EXEC (one cycle): ALU operands driven from the latched instruction; at the next edge alu_res is written to Rd, wb_addr/wb_data registered; -> WB.
REQ-021 WB (one cycle): wb_valid=1 with wb_addr/wb_data valid; -> IDLE.
REQ-022 ERR (one cycle): illegal=1; no register write; -> IDLE.
REQ-023 Latency: instruction accepted at edge k; register updated at edge k+1; wb_valid high in cycle k+1..k+2; instr_ready high again from edge k+2. Throughput one instruction per 3 cycles.
REQ-024 instr_valid while instr_ready=0 SHALL be ignored; the instruction SHALL be accepted in the next IDLE cycle if still presented.
REQ-025 Rd=Rs SHALL use the pre-write value for both operands.
REQ-026 wb_addr/wb_data SHALL hold their last values when wb_valid=0.

Reset
REQ-027 On rst, asynchronously: state=IDLE, R0-R3=0, wb_valid=0, wb_addr=0, wb_data=0, illegal=0, latched instruction=0.
REQ-028 instr_ready SHALL be 1 while rst is held and after release.
REQ-029 Reset during EXEC or WB SHALL abort the instruction; no write survives reset.

Configuration
REQ-030 Macro ALU_CTRL_ZFLAG_EN defined: an extra output zflag (1 bit) SHALL be added, registered at the EXEC->WB edge as (alu_res==0), held otherwise, and reset to 0.
REQ-031 Macro ALU_CTRL_ZFLAG_EN undefined: the zflag port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 LOADI R1,0x05; LOADI R2,0x03; ADD R1,R2 -> final wb_valid pulse with wb_addr=1, wb_data=0x08; alu_op=0x01 during EXEC.
REQ-033 R1=0x03, R2=0x05; SUB R1,R2 -> alu_b=0xFB in EXEC; wb_data=0xFE; R1=0xFE.
REQ-034 R0=0xFF, R3=0x01; ADD R0,R3 -> wb_data=0x00; with ALU_CTRL_ZFLAG_EN, zflag=1 in WB.
REQ-035 instr opcode 110 -> illegal pulses for one cycle, no wb_valid, registers unchanged, instr_ready high 2 cycles after acceptance.
REQ-036 instr_valid held high continuously with 3 instructions -> exactly one acceptance every 3 cycles; no instruction dropped or duplicated.
REQ-037 rst asserted during EXEC of LOADI R2,0xAA -> no wb_valid; R2=0x00; state IDLE; instr_ready=1.
